// File: rtl/m5_mem_pkg.sv
// Shared types and constants for the Sord M5 SDRAM arbiter and its download FIFO.
package m5_mem_pkg;

    // SDRAM byte address width seen by the controller.
    localparam int SD_AW = 25;

    // Default SDRAM byte address where CAS tape images are relocated.
    localparam logic [SD_AW-1:0] TAPE_BASE_DEF = 25'h100000;

    // Download FIFO entry width: {mapped address, data byte}.
    localparam int DL_FIFO_W = SD_AW + 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        G_DL   = 2'd0,
        G_CPU  = 2'd1,
        G_TAPE = 2'd2
    } grant_t;

    // CAS downloads land in the tape region; everything else is written as addressed.
    function automatic logic [SD_AW-1:0] dl_map_addr(
        input logic             is_cas,
        input logic [SD_AW-1:0] base,
        input logic [SD_AW-1:0] addr
    );
        return is_cas ? (base + addr) : addr;
    endfunction

endpackage

// File: rtl/m5_dl_fifo.sv
// Small synchronous FIFO buffering ioctl download bytes. A push while full is
// accepted only if a pop happens in the same cycle; otherwise it is dropped and
// push_drop flags it for that cycle.
module m5_dl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             push_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign push_drop = push && !push_ok;

    // Head entry is read combinationally so the arbiter can latch it in the pop cycle.
    assign pop_data = mem_q[rd_ptr_q];

    // Next pointer and occupancy; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/m5_sdram_arbiter.sv
// Arbitrates the single SDRAM port of the Sord M5 core between the ioctl
// download writer, the Z80 memory path and the tape playback reader.
module m5_sdram_arbiter
    import m5_mem_pkg::*;
#(
    parameter logic [SD_AW-1:0] TAPE_BASE     = TAPE_BASE_DEF,
    parameter logic [7:0]       TAPE_IDX      = 8'd2,
    parameter int               TAPE_MAX_WAIT = 64,
    parameter int               FIFO_DEPTH    = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             dl_download,
    input  logic [7:0]       dl_index,
    input  logic             dl_wr,
    input  logic [SD_AW-1:0] dl_addr,
    input  logic [7:0]       dl_data,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [SD_AW-1:0] cpu_addr,
    input  logic [7:0]       cpu_din,
    output logic [7:0]       cpu_dout,
    output logic             cpu_ack,
    input  logic             tape_req,
    input  logic [SD_AW-1:0] tape_addr,
    output logic [7:0]       tape_dout,
    output logic             tape_ack,
    output logic [SD_AW-1:0] tape_len,
    output logic             sd_req,
    output logic             sd_we,
    output logic [SD_AW-1:0] sd_addr,
    output logic [7:0]       sd_din,
    input  logic [7:0]       sd_dout,
    input  logic             sd_ack,
    output logic             dl_ovf
);

    localparam int              AGE_W   = $clog2(TAPE_MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TAPE_MAX_WAIT);
    localparam logic [AGE_W-1:0] AGE_ONE = 1;
    localparam logic [SD_AW-1:0] ADDR_ONE = 1;

    // Download FIFO plumbing.
    logic                 is_cas;
    logic [DL_FIFO_W-1:0] fifo_wdata;
    logic [DL_FIFO_W-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_drop;
    logic                 fifo_pop;

    // Bookkeeping registers.
    logic             dl_ovf_q, dl_ovf_d;
    logic [SD_AW-1:0] tape_len_q, tape_len_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             tape_aged;
    logic             tape_busy;

    // Arbiter state and registered outputs.
    arb_state_t       state_q, state_d;
    grant_t           grant_q, grant_d;
    grant_t           grant_sel;
    logic             grant_valid;
    logic             sd_req_q, sd_req_d;
    logic             sd_we_q, sd_we_d;
    logic [SD_AW-1:0] sd_addr_q, sd_addr_d;
    logic [7:0]       sd_din_q, sd_din_d;
    logic             cpu_ack_q, cpu_ack_d;
    logic [7:0]       cpu_dout_q, cpu_dout_d;
    logic             tape_ack_q, tape_ack_d;
    logic [7:0]       tape_dout_q, tape_dout_d;

    assign is_cas     = (dl_index == TAPE_IDX);
    assign fifo_wdata = {dl_map_addr(is_cas, TAPE_BASE, dl_addr), dl_data};

    m5_dl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DL_FIFO_W)
    ) u_dl_fifo (
        .clk       (clk_sys),
        .rst       (reset),
        .push      (dl_wr),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (fifo_drop)
    );

    assign tape_aged = (age_q == AGE_MAX);
    assign tape_busy = (state_q != IDLE) && (grant_q == G_TAPE);

    // Requester selection at IDLE: pending download bytes first, then an aged tape,
    // then the CPU, then a fresh tape. The core is held in reset while downloading,
    // so CPU and tape are not served then.
    always_comb begin
        grant_sel   = G_DL;
        grant_valid = 1'b0;
        if (!fifo_empty) begin
            grant_sel   = G_DL;
            grant_valid = 1'b1;
        end else if (!dl_download && tape_req && tape_aged) begin
            grant_sel   = G_TAPE;
            grant_valid = 1'b1;
        end else if (!dl_download && cpu_req) begin
            grant_sel   = G_CPU;
            grant_valid = 1'b1;
        end else if (!dl_download && tape_req) begin
            grant_sel   = G_TAPE;
            grant_valid = 1'b1;
        end
    end

    // Overflow flag, tape image length and tape starvation counter.
    always_comb begin
        dl_ovf_d   = dl_ovf_q | fifo_drop;
        tape_len_d = tape_len_q;
        age_d      = age_q;
        if (dl_wr && is_cas) begin
            tape_len_d = dl_addr + ADDR_ONE;
        end
        if ((state_q == IDLE) && grant_valid && (grant_sel == G_TAPE)) begin
            age_d = '0;
        end else if (tape_req && !tape_busy && (age_q != AGE_MAX)) begin
            age_d = age_q + AGE_ONE;
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_ovf_q   <= 1'b0;
            tape_len_q <= '0;
            age_q      <= '0;
        end else begin
            dl_ovf_q   <= dl_ovf_d;
            tape_len_q <= tape_len_d;
            age_q      <= age_d;
        end
    end

    // Access sequencer: latch a command in IDLE, hold it through ISSUE until the
    // controller acks, then give the requester its one-cycle ack during DONE.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sd_req_d    = sd_req_q;
        sd_we_d     = sd_we_q;
        sd_addr_d   = sd_addr_q;
        sd_din_d    = sd_din_q;
        cpu_dout_d  = cpu_dout_q;
        tape_dout_d = tape_dout_q;
        cpu_ack_d   = 1'b0;
        tape_ack_d  = 1'b0;
        fifo_pop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    grant_d  = grant_sel;
                    sd_req_d = 1'b1;
                    state_d  = ISSUE;
                    unique case (grant_sel)
                        G_DL: begin
                            fifo_pop  = 1'b1;
                            sd_we_d   = 1'b1;
                            sd_addr_d = fifo_rdata[DL_FIFO_W-1:8];
                            sd_din_d  = fifo_rdata[7:0];
                        end
                        G_CPU: begin
                            sd_we_d   = cpu_we;
                            sd_addr_d = cpu_addr;
                            sd_din_d  = cpu_din;
                        end
                        default: begin
                            sd_we_d   = 1'b0;
                            sd_addr_d = TAPE_BASE + tape_addr;
                            sd_din_d  = 8'h00;
                        end
                    endcase
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    sd_req_d = 1'b0;
                    state_d  = DONE;
                    // Ack is registered here so it is visible exactly during DONE.
                    unique case (grant_q)
                        G_CPU: begin
                            cpu_ack_d = 1'b1;
                            if (!sd_we_q) begin
                                cpu_dout_d = sd_dout;
                            end
                        end
                        G_TAPE: begin
                            tape_ack_d  = 1'b1;
                            tape_dout_d = sd_dout;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            DONE: begin
                // Requests are not sampled here so the requester can drop its req.
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                sd_req_d = 1'b0;
            end
        endcase
    end

    // Arbiter state and all registered SDRAM/requester outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= G_DL;
            sd_req_q    <= 1'b0;
            sd_we_q     <= 1'b0;
            sd_addr_q   <= '0;
            sd_din_q    <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_dout_q  <= '0;
            tape_ack_q  <= 1'b0;
            tape_dout_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sd_req_q    <= sd_req_d;
            sd_we_q     <= sd_we_d;
            sd_addr_q   <= sd_addr_d;
            sd_din_q    <= sd_din_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_dout_q  <= cpu_dout_d;
            tape_ack_q  <= tape_ack_d;
            tape_dout_q <= tape_dout_d;
        end
    end

    assign sd_req    = sd_req_q;
    assign sd_we     = sd_we_q;
    assign sd_addr   = sd_addr_q;
    assign sd_din    = sd_din_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_dout  = cpu_dout_q;
    assign tape_ack  = tape_ack_q;
    assign tape_dout = tape_dout_q;
    assign tape_len  = tape_len_q;
    assign dl_ovf    = dl_ovf_q;

endmodule

// File: tb/tb_m5_sdram_arbiter.sv
// Scoreboard bench for m5_sdram_arbiter with a behavioural SDRAM controller model.
module tb_m5_sdram_arbiter;

    localparam logic [24:0] TB_TAPE_BASE = 25'h100000;

    typedef struct packed {
        logic        we;
        logic [24:0] addr;
        logic [7:0]  din;
    } cmd_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_download;
    logic [7:0]  dl_index;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        tape_req;
    logic [24:0] tape_addr;
    logic [7:0]  tape_dout;
    logic        tape_ack;
    logic [24:0] tape_len;
    logic        sd_req;
    logic        sd_we;
    logic [24:0] sd_addr;
    logic [7:0]  sd_din;
    logic [7:0]  sd_dout;
    logic        sd_ack;
    logic        dl_ovf;

    // Controller model state.
    logic        model_ack;
    logic [7:0]  model_dout;
    logic        stray_ack;
    int          ctl_lat;
    logic        ctl_en;
    logic [7:0]  mem_m [logic [24:0]];

    // Scoreboard.
    cmd_t        exp_cmd[$];
    logic [7:0]  exp_cpu[$];
    logic [7:0]  exp_tape[$];
    logic        sb_cmd_en;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign sd_ack  = model_ack | stray_ack;
    assign sd_dout = model_dout;

    always #5 clk_sys = ~clk_sys;

    m5_sdram_arbiter dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .dl_download (dl_download),
        .dl_index    (dl_index),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_ack     (cpu_ack),
        .tape_req    (tape_req),
        .tape_addr   (tape_addr),
        .tape_dout   (tape_dout),
        .tape_ack    (tape_ack),
        .tape_len    (tape_len),
        .sd_req      (sd_req),
        .sd_we       (sd_we),
        .sd_addr     (sd_addr),
        .sd_din      (sd_din),
        .sd_dout     (sd_dout),
        .sd_ack      (sd_ack),
        .dl_ovf      (dl_ovf)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [24:0] a);
        logic [7:0] v;
        v = a[7:0] ^ 8'h5A;
        if (mem_m.exists(a)) v = mem_m[a];
        return v;
    endfunction

    // SDRAM controller model: acks in the ctl_lat-th cycle of a request.
    initial begin
        int cnt;
        cnt        = 0;
        model_ack  = 1'b0;
        model_dout = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            if (reset || !ctl_en) begin
                cnt       = 0;
                model_ack = 1'b0;
            end else if (sd_req && !model_ack) begin
                cnt++;
                if (cnt >= ctl_lat) begin
                    cnt       = 0;
                    model_ack = 1'b1;
                    if (sd_we) mem_m[sd_addr] = sd_din;
                    else model_dout = mem_rd(sd_addr);
                end
            end else begin
                model_ack = 1'b0;
            end
        end
    end

    // Monitor: pops expected commands and read data as the DUT produces them.
    initial begin
        logic  req_prev, cack_prev, tack_prev;
        cmd_t  cur, e;
        req_prev  = 1'b0;
        cack_prev = 1'b0;
        tack_prev = 1'b0;
        cur       = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                if (sd_req && !req_prev) begin
                    cur = {sd_we, sd_addr, sd_din};
                    if (sb_cmd_en) begin
                        chk_eq("cmd_expected", 32'(exp_cmd.size() > 0), 32'd1);
                        if (exp_cmd.size() > 0) begin
                            e = exp_cmd.pop_front();
                            chk_eq("cmd_we", 32'(sd_we), 32'(e.we));
                            chk_eq("cmd_addr", 32'(sd_addr), 32'(e.addr));
                            chk_eq("cmd_din", 32'(sd_din), 32'(e.din));
                        end
                    end
                end else if (sd_req) begin
                    chk_eq("cmd_stable", 32'({sd_we, sd_addr, sd_din}), 32'(cur));
                end
                if (cpu_ack) begin
                    chk_eq("cpu_ack_width", 32'(cack_prev), 32'd0);
                    if (!cpu_we) begin
                        chk_eq("cpu_rd_expected", 32'(exp_cpu.size() > 0), 32'd1);
                        if (exp_cpu.size() > 0) chk_eq("cpu_dout", 32'(cpu_dout), 32'(exp_cpu.pop_front()));
                    end
                end
                if (tape_ack) begin
                    chk_eq("tape_ack_width", 32'(tack_prev), 32'd0);
                    chk_eq("tape_rd_expected", 32'(exp_tape.size() > 0), 32'd1);
                    if (exp_tape.size() > 0) chk_eq("tape_dout", 32'(tape_dout), 32'(exp_tape.pop_front()));
                end
            end
            req_prev  = sd_req;
            cack_prev = cpu_ack;
            tack_prev = tape_ack;
        end
    end

    task automatic cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [24:0] a, input logic [7:0] d, input int budget);
        logic got;
        if (!we) exp_cpu.push_back(mem_rd(a));
        cpu_we   = we;
        cpu_addr = a;
        cpu_din  = d;
        cpu_req  = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        chk_eq("cpu_ack_seen", 32'(got), 32'd1);
        $display("cpu access we=%0b addr=0x%0h done=%0b", we, a, got);
    endtask

    task automatic tape_access(input logic [24:0] a, input int budget, output int wait_cyc);
        logic got;
        exp_tape.push_back(mem_rd(TB_TAPE_BASE + a));
        tape_addr = a;
        tape_req  = 1'b1;
        got       = 1'b0;
        wait_cyc  = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            wait_cyc++;
            if (tape_ack) got = 1'b1;
        end
        tape_req = 1'b0;
        chk_eq("tape_ack_seen", 32'(got), 32'd1);
        $display("tape read off=0x%0h cycles=%0d done=%0b", a, wait_cyc, got);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset       = 1'b1;
        dl_download = 1'b0;
        dl_index    = 8'd0;
        dl_wr       = 1'b0;
        dl_addr     = '0;
        dl_data     = '0;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_din     = '0;
        tape_req    = 1'b0;
        tape_addr   = '0;
        stray_ack   = 1'b0;
        ctl_en      = 1'b1;
        ctl_lat     = 5;
        sb_cmd_en   = 1'b1;
        mem_m[25'h123] = 8'hA5;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Reset state.
        chk_eq("rst_ctrl", 32'({sd_req, sd_we, cpu_ack, tape_ack, dl_ovf}), 32'd0);
        chk_eq("rst_sd_addr", 32'(sd_addr), 32'd0);
        chk_eq("rst_tape_len", 32'(tape_len), 32'd0);
        chk_eq("rst_dout", 32'({cpu_dout, tape_dout, sd_din}), 32'd0);
        $display("reset state checked");

        // CPU read with exact timing: req sampled in cycle 0.
        exp_cmd.push_back({1'b0, 25'h123, 8'h00});
        exp_cpu.push_back(8'hA5);
        cpu_we = 1'b0; cpu_addr = 25'h123; cpu_din = 8'h00; cpu_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            chk_eq("rd_sd_req", 32'(sd_req), 32'(c <= 5));
            chk_eq("rd_cpu_ack", 32'(cpu_ack), 32'(c == 6));
            if (c == 6) begin
                chk_eq("rd_cpu_dout_a5", 32'(cpu_dout), 32'h0A5);
                cpu_req = 1'b0;
            end
        end
        $display("cpu read 0x123 timing checked");

        // CAS download burst: 3 bytes, one strobe every 2 cycles, latency 8.
        ctl_lat = 8;
        dl_download = 1'b1;
        dl_index    = 8'd2;
        for (int i = 0; i < 3; i++) begin
            exp_cmd.push_back({1'b1, TB_TAPE_BASE + 25'(i), 8'hC0 + 8'(i)});
            dl_wr = 1'b1; dl_addr = 25'(i); dl_data = 8'hC0 + 8'(i);
            cycle();
            dl_wr = 1'b0;
            cycle();
            $display("cas push off=%0d data=0x%0h", i, 8'hC0 + 8'(i));
        end
        repeat (40) cycle();
        dl_download = 1'b0;
        chk_eq("cas_tape_len", 32'(tape_len), 32'd3);
        chk_eq("cas_ovf", 32'(dl_ovf), 32'd0);
        chk_eq("cas_drained", 32'(exp_cmd.size()), 32'd0);

        // FIFO overflow: 6 back-to-back strobes, latency 20; the 6th is dropped.
        ctl_lat = 20;
        dl_download = 1'b1;
        dl_index    = 8'd0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_cmd.push_back({1'b1, 25'h400 + 25'(i), 8'h30 + 8'(i)});
            dl_wr = 1'b1; dl_addr = 25'h400 + 25'(i); dl_data = 8'h30 + 8'(i);
            cycle();
            $display("dl push addr=0x%0h", 25'h400 + 25'(i));
        end
        dl_wr = 1'b0;
        chk_eq("ovf_set", 32'(dl_ovf), 32'd1);
        repeat (130) cycle();
        chk_eq("ovf_sticky", 32'(dl_ovf), 32'd1);
        chk_eq("ovf_drained", 32'(exp_cmd.size()), 32'd0);
        chk_eq("ovf_tape_len_kept", 32'(tape_len), 32'd3);

        // CPU blocked during download, granted right after it ends.
        ctl_lat = 3;
        exp_cmd.push_back({1'b0, 25'h300, 8'h00});
        exp_cpu.push_back(mem_rd(25'h300));
        cpu_we = 1'b0; cpu_addr = 25'h300; cpu_din = 8'h00; cpu_req = 1'b1;
        begin
            int hi;
            logic got;
            hi = 0;
            repeat (20) begin
                cycle();
                hi += int'(sd_req);
            end
            chk_eq("blk_no_grant", 32'(hi), 32'd0);
            dl_download = 1'b0;
            chk_eq("blk_cycle0_req", 32'(sd_req), 32'd0);
            cycle();
            chk_eq("blk_cycle1_req", 32'(sd_req), 32'd1);
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                cycle();
                if (cpu_ack) got = 1'b1;
            end
            cpu_req = 1'b0;
            chk_eq("blk_ack_seen", 32'(got), 32'd1);
            $display("cpu read 0x300 after download done=%0b", got);
        end
        cycle();

        // CPU and tape requests together: CPU first, then tape.
        exp_cmd.push_back({1'b0, 25'h500, 8'h00});
        exp_cmd.push_back({1'b0, TB_TAPE_BASE + 25'h10, 8'h00});
        fork
            cpu_access(1'b0, 25'h500, 8'h00, 100);
            tape_access(25'h10, 100, w);
        join
        cycle();
        chk_eq("pair_drained", 32'(exp_cmd.size()), 32'd0);

        // Tape aging against a continuously requesting CPU, latency 2.
        ctl_lat   = 2;
        sb_cmd_en = 1'b0;
        cpu_we = 1'b1; cpu_addr = 25'h200; cpu_din = 8'h11; cpu_req = 1'b1;
        repeat (10) cycle();
        tape_access(25'h40, 200, w);
        chk_eq("age_first_wait_in_64_72", 32'(w >= 64 && w <= 72), 32'd1);
        tape_access(25'h41, 200, w);
        chk_eq("age_cleared_wait_in_64_72", 32'(w >= 64 && w <= 72), 32'd1);
        cpu_req = 1'b0;
        repeat (10) cycle();
        sb_cmd_en = 1'b1;

        // Reset during ISSUE, then a stray controller ack.
        ctl_en    = 1'b0;
        sb_cmd_en = 1'b0;
        cpu_we = 1'b0; cpu_addr = 25'h600; cpu_req = 1'b1;
        repeat (3) cycle();
        chk_eq("midrst_in_issue", 32'(sd_req), 32'd1);
        reset   = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk_eq("midrst_async_clear", 32'(sd_req), 32'd0);
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        stray_ack = 1'b1;
        cycle();
        stray_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk_eq("midrst_ctrl", 32'({sd_req, sd_we, cpu_ack, tape_ack, dl_ovf}), 32'd0);
            chk_eq("midrst_data", 32'({cpu_dout, tape_dout, sd_din}), 32'd0);
            chk_eq("midrst_addr_len", 32'(sd_addr | tape_len), 32'd0);
        end
        $display("reset in ISSUE and stray ack checked");

        chk_eq("end_cpu_q", 32'(exp_cpu.size()), 32'd0);
        chk_eq("end_tape_q", 32'(exp_tape.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
